// File: rtl/weighted_pop_sched_pkg.sv
// Shared definitions for the weighted round-robin FIFO pop scheduler.
package weighted_pop_sched_pkg;

  localparam int NUM_Q_DEF    = 4;
  localparam int WEIGHT_W_DEF = 3;
  localparam int IDX_W        = 2;

  typedef enum logic [0:0] {
    SELECT = 1'b0,
    SERVE  = 1'b1
  } state_e;

  // Successor of a queue index, wrapping at the queue count.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int nq);
    logic [IDX_W-1:0] r;
    if (int'(idx) == nq - 1) begin
      r = '0;
    end else begin
      r = idx + IDX_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/weighted_pop_sched_rr_find_next.sv
// Rotating first-eligible search: scans ptr, ptr+1, ... wrapping, reports the first hit.
module rr_find_next
  import weighted_pop_sched_pkg::*;
#(
  parameter int NUM_Q = NUM_Q_DEF
) (
  input  logic [NUM_Q-1:0] eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] sel_o
);

  // Scan from the farthest offset back to ptr so the nearest eligible queue wins.
  always_comb begin
    found_o = 1'b0;
    sel_o   = '0;
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      logic [IDX_W-1:0] idx;
      idx     = IDX_W'((int'(ptr_i) + k) % NUM_Q);
      found_o = found_o | eligible_i[idx];
      sel_o   = eligible_i[idx] ? idx : sel_o;
    end
  end

endmodule

// File: rtl/weighted_pop_sched.sv
// Weighted round-robin pop scheduler: each non-empty queue with non-zero weight
// receives up to its weight in consecutive pops per turn, with one SELECT
// bubble between turns.
module weighted_pop_sched
  import weighted_pop_sched_pkg::*;
#(
  parameter int NUM_Q    = NUM_Q_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_Q-1:0]          empty,
  input  logic                      pause,
  input  logic                      cfg_load,
  input  logic [NUM_Q*WEIGHT_W-1:0] cfg_weights,
  output logic [NUM_Q-1:0]          pop,
  output logic [IDX_W-1:0]          pop_id,
  output logic                      valid
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [WEIGHT_W-1:0]   wt_q [NUM_Q];
  logic                  valid_q;
  logic [IDX_W-1:0]      pop_id_q;

  logic [NUM_Q-1:0]      eligible_s;
  logic                  found_s;
  logic [IDX_W-1:0]      sel_s;
  logic [NUM_Q-1:0]      pop_s;

  // A queue competes only when it holds data and has a non-zero weight.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      eligible_s[i] = ~empty[i] & (wt_q[i] != '0);
    end
  end

  rr_find_next #(
    .NUM_Q(NUM_Q)
  ) u_find (
    .eligible_i(eligible_s),
    .ptr_i     (ptr_q),
    .found_o   (found_s),
    .sel_o     (sel_s)
  );

  // Weight table; a reload never touches the credit of the quantum in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_Q; i++) begin
        wt_q[i] <= WEIGHT_W'(1);
      end
    end else if (cfg_load) begin
      for (int i = 0; i < NUM_Q; i++) begin
        wt_q[i] <= cfg_weights[i*WEIGHT_W +: WEIGHT_W];
      end
    end else begin
      wt_q <= wt_q;
    end
  end

  // FSM state register; reset abandons any quantum and restarts the search at queue 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SELECT;
      ptr_q    <= '0;
      cur_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
    end
  end

  // Next-state logic: pick a queue in SELECT, spend credit in SERVE.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    case (state_q)
      SELECT: begin
        if (found_s && !pause) begin
          state_d  = SERVE;
          cur_d    = sel_s;
          credit_d = wt_q[sel_s];
        end else begin
          state_d  = SELECT;
        end
      end
      SERVE: begin
        if (pause) begin
          state_d  = SERVE;
        end else if (empty[cur_q]) begin
          // Queue ran dry: drop leftover credit and move on.
          state_d  = SELECT;
          ptr_d    = next_idx(cur_q, NUM_Q);
        end else if (credit_q > WEIGHT_W'(1)) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end else begin
          state_d  = SELECT;
          ptr_d    = next_idx(cur_q, NUM_Q);
        end
      end
      default: begin
        state_d  = SELECT;
      end
    endcase
  end

  // Combinational pop strobe: only the served queue, only when it has data and downstream has room.
  always_comb begin
    pop_s = '0;
    if (!reset && (state_q == SERVE) && !empty[cur_q] && !pause) begin
      pop_s[cur_q] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  // Read-data qualifiers for the pop issued in the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pop_id_q <= '0;
    end else begin
      valid_q  <= |pop_s;
      pop_id_q <= (|pop_s) ? cur_q : pop_id_q;
    end
  end

  assign pop    = pop_s;
  assign valid  = valid_q;
  assign pop_id = pop_id_q;

endmodule

// File: tb/tb_weighted_pop_sched.sv
// Randomized self-checking bench for weighted_pop_sched with a turn-based reference model.
module tb_weighted_pop_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  empty = 4'b0000;
  logic        pause = 1'b0;
  logic        cfg_load = 1'b0;
  logic [11:0] cfg_weights = 12'h000;
  logic [3:0]  pop;
  logic [1:0]  pop_id;
  logic        valid;

  always #5 clk = ~clk;

  weighted_pop_sched dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .pause      (pause),
    .cfg_load   (cfg_load),
    .cfg_weights(cfg_weights),
    .pop        (pop),
    .pop_id     (pop_id),
    .valid      (valid)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a "turn" owns one queue and a number of pops left.
  bit m_busy  = 1'b0;
  int m_q     = 0;
  int m_left  = 0;
  int m_start = 0;
  int m_wt [4] = '{1, 1, 1, 1};
  bit m_valid = 1'b0;
  int m_id    = 0;

  logic [3:0] s_pop;
  logic       s_valid;
  logic [1:0] s_id;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_empty(input int q);
    return ((empty >> q) & 4'b0001) != 4'b0000;
  endfunction

  // One clock: compare outputs mid-cycle, advance the model, return just after the edge.
  task automatic step();
    logic [3:0] e_pop;
    int found;
    @(negedge clk);
    e_pop = 4'b0000;
    if (!reset && m_busy && !is_empty(m_q) && !pause) e_pop = 4'b0001 << m_q;
    check_val("pop", 32'(pop), 32'(e_pop));
    check_val("valid", 32'(valid), 32'(m_valid));
    check_val("pop_id", 32'(pop_id), 32'(m_id));
    s_pop = pop; s_valid = valid; s_id = pop_id;
    if (reset) begin
      m_busy = 1'b0; m_start = 0; m_q = 0; m_left = 0; m_valid = 1'b0; m_id = 0;
      for (int i = 0; i < 4; i++) m_wt[i] = 1;
    end else begin
      m_valid = (e_pop != 4'b0000);
      if (e_pop != 4'b0000) m_id = m_q;
      if (!m_busy) begin
        found = -1;
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_start + k) % 4;
          if (found < 0 && !is_empty(idx) && m_wt[idx] != 0) found = idx;
        end
        if (found >= 0 && !pause) begin
          m_busy = 1'b1; m_q = found; m_left = m_wt[found];
        end
      end else if (!pause) begin
        if (is_empty(m_q)) begin
          m_busy = 1'b0; m_start = (m_q + 1) % 4;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_busy = 1'b0; m_start = (m_q + 1) % 4;
          end
        end
      end
      if (cfg_load) begin
        for (int i = 0; i < 4; i++) m_wt[i] = int'((cfg_weights >> (i * 3)) & 12'h007);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_pop_tbl [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010,
                                  4'b0000, 4'b0100, 4'b0000, 4'b1000};
  int pat [6] = '{0, 0, 0, 1, 3, 3};
  int ids [$];

  initial begin
    // Equal weights, all queues full: one pop every other cycle in rotation.
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check_val("rr_pop_seq", 32'(s_pop), 32'(exp_pop_tbl[c]));
    end

    // Weights q0:3 q1:1 q2:0 q3:2.
    reset = 1'b1; step();
    reset = 1'b0; pause = 1'b1; cfg_load = 1'b1; cfg_weights = {3'd2, 3'd0, 3'd1, 3'd3};
    step();
    pause = 1'b0; cfg_load = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (s_valid) ids.push_back(int'(s_id));
    end
    for (int n = 0; n < 18; n++) begin
      if (n < ids.size()) check_val("wt_seq", 32'(ids[n]), 32'(pat[n % 6]));
      else check_val("wt_seq_len", 32'(ids.size()), 32'd18);
    end

    // All empty, then only queue 3 fills.
    empty = 4'b1111;
    for (int c = 0; c < 8; c++) step();
    empty = 4'b0111;
    step(); step();
    check_val("q3_wakeup", 32'(s_pop), 32'(4'b1000));

    // Randomized traffic, pauses, reloads and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) empty[i] = ($urandom_range(0, 9) < 3);
      pause       = ($urandom_range(0, 9) < 2);
      cfg_load    = ($urandom_range(0, 19) == 0);
      cfg_weights = 12'($urandom);
      reset       = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
